// File: rtl/rca_slice_sequencer.sv
// Sequencer that feeds one shared ripple-carry adder slice with successive operand slices,
// least significant first, holding the carry in a register between steps.
module rca_slice_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SLICE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               busy,
  output logic [SLICE_W-1:0] slice_a,
  output logic [SLICE_W-1:0] slice_b,
  output logic               slice_cin,
  input  logic [SLICE_W-1:0] slice_sum,
  input  logic               slice_cout
);

  localparam int unsigned STEPS = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= slice_sum;
          r_carry                         <= slice_cout;
          if (r_idx == LastIdx) begin
            r_cout  <= slice_cout;
            r_idx   <= '0;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign sum       = r_sum;
  assign cout      = r_cout;

  // The slice only sees operand bits while a step is in flight.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (r_state == StRun) begin
      slice_a   = r_a[r_idx*SLICE_W +: SLICE_W];
      slice_b   = r_b[r_idx*SLICE_W +: SLICE_W];
      slice_cin = r_carry;
    end
  end

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Randomized scoreboard bench: accepted operands push a+b+cin into a queue, a monitor checks
// results, latency, spacing and the per-step slice drive against arithmetic expectations.
module tb_rca_slice_sequencer;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SLICE_W = 2;
  localparam int unsigned STEPS   = WIDTH / SLICE_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, cin, out_valid, out_ready, cout, busy, slice_cin;
  logic               slice_cout;
  logic [WIDTH-1:0]   a, b, sum;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;

  rca_slice_sequencer #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_sum(slice_sum),
    .slice_cout(slice_cout)
  );

  // Ideal adder slice beside the controller.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} +
                                   {{SLICE_W{1'b0}}, slice_cin};

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [WIDTH:0] exp_q[$];
  int acc_q[$];
  int cur_a, cur_b, cur_cin, cur_acc;
  int last_acc = -1;
  bit b2b = 1'b0;
  bit prev_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance monitor: the expected response is a+b+cin at WIDTH+1 bits.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_vs_busy", {31'b0, in_ready}, {31'b0, !busy});
      if (in_valid && in_ready) begin
        exp_q.push_back((WIDTH+1)'(int'(a) + int'(b) + int'(cin)));
        acc_q.push_back(cyc);
        cur_a = int'(a); cur_b = int'(b); cur_cin = int'(cin); cur_acc = cyc;
        if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, STEPS + 2);
        last_acc = cyc;
      end
    end
  end

  // Result and slice-drive monitor.
  always @(negedge clk) begin
    int step, lowm, part;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (busy && !out_valid) begin
        step = cyc - cur_acc - 1;
        lowm = (1 << (step * SLICE_W)) - 1;
        part = (cur_a & lowm) + (cur_b & lowm) + cur_cin;
        chk("run_step_range", (step >= 0 && step < int'(STEPS)) ? 1 : 0, 1);
        chk("slice_a", slice_a, (cur_a >> (step * SLICE_W)) & ((1 << SLICE_W) - 1));
        chk("slice_b", slice_b, (cur_b >> (step * SLICE_W)) & ((1 << SLICE_W) - 1));
        chk("slice_cin", slice_cin, (part >> (step * SLICE_W)) & 1);
      end else begin
        chk("slice_idle_zero", {slice_a, slice_b, slice_cin}, 0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("sum", sum, exp_q[0][WIDTH-1:0]);
          chk("cout", cout, exp_q[0][WIDTH]);
          if (!prev_ov && acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), STEPS + 1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; optionally leave in_valid asserted afterwards.
  task automatic do_add(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input bit keep);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum_cout", {sum, cout}, 0);
    chk("rst_slice", {slice_a, slice_b, slice_cin}, 0);
    rst = 1'b0;
    tick();

    do_add(8'hFF, 8'h01, 1'b0, 1'b0); wait_drain();
    do_add(8'h00, 8'h00, 1'b1, 1'b0); wait_drain();
    do_add(8'hA5, 8'h5A, 1'b1, 1'b0); wait_drain();

    // Consumer stall: result must hold in DONE.
    out_ready = 1'b0;
    do_add(8'h12, 8'h34, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("stall_out_valid", out_valid, 1);
    repeat (10) tick();
    chk("stall_held", out_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // in_valid held with operands changing every cycle; only IDLE accepts may count.
    last_acc = -1; b2b = 1'b1;
    in_valid = 1'b1;
    repeat (20) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; b2b = 1'b0;
    wait_drain();

    // Reset in RUN step 2.
    do_add(8'h77, 8'h66, 1'b1, 1'b0);
    tick(); tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum_cout", {sum, cout}, 0);
    chk("mid_rst_slice", {slice_a, slice_b, slice_cin}, 0);
    exp_q.delete(); acc_q.delete();
    tick();
    rst = 1'b0;
    tick();
    do_add(8'h0F, 8'h01, 1'b0, 1'b0); wait_drain();

    // Back-to-back random adds.
    last_acc = -1; b2b = 1'b1;
    repeat (3) do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    b2b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
